// File: rtl/output_router_pkg.sv
// ============================================================================
// Module      : output_router_pkg
// Description : Shared FSM encoding and router geometry helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package output_router_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Elements packed into one SPAD word.
   function automatic int member_cnt(input int spad_w, input int data_w);
      return (spad_w + data_w - 1) / data_w;
   endfunction

   // SPAD words produced per row of router inputs.
   function automatic int group_cnt(input int router_count, input int member);
      return (router_count + member - 1) / member;
   endfunction

endpackage

`default_nettype wire

// File: rtl/output_writeback_ctrl.sv
// ============================================================================
// Module      : output_writeback_ctrl
// Description : Paces PE result rows into the output router and writes packed words to SPAD.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module output_writeback_ctrl
   import output_router_pkg::*;
#(
   parameter int SPAD_ADDR_WIDTH = 8,
   parameter int SPAD_DATA_WIDTH = 16,
   parameter int ROUTER_COUNT    = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int ROW_CNT_WIDTH   = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [SPAD_ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ROW_CNT_WIDTH-1:0]   i_row_count,
   input  logic                       i_pe_valid,
   output logic                       o_pe_ack,
   output logic                       o_router_en,
   input  logic                       i_router_valid,
   output logic                       o_spad_wr_en,
   output logic [SPAD_ADDR_WIDTH-1:0] o_spad_addr,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   localparam int MEMBER_CNT = member_cnt(SPAD_DATA_WIDTH, DATA_WIDTH);
   localparam int GROUP_CNT  = group_cnt(ROUTER_COUNT, MEMBER_CNT);
   localparam int CD_W       = $clog2(GROUP_CNT + 1);
   localparam int WR_W       = ROW_CNT_WIDTH + CD_W;

   localparam logic [CD_W-1:0]            c_cool_init = CD_W'(GROUP_CNT);
   localparam logic [CD_W-1:0]            c_cool_one  = CD_W'(1);
   localparam logic [WR_W-1:0]            c_group_w   = WR_W'(GROUP_CNT);
   localparam logic [ROW_CNT_WIDTH-1:0]   c_row_one   = ROW_CNT_WIDTH'(1);
   localparam logic [SPAD_ADDR_WIDTH-1:0] c_addr_one  = SPAD_ADDR_WIDTH'(1);

   state_t                       r_state;
   logic [ROW_CNT_WIDTH-1:0]     r_rows;
   logic [ROW_CNT_WIDTH-1:0]     r_issued;
   logic [WR_W-1:0]              r_total;
   logic [WR_W-1:0]              r_written;
   logic [CD_W-1:0]              r_cool;
   logic [SPAD_ADDR_WIDTH-1:0]   r_wr_addr;
   logic                         r_err;

   logic                         w_start;
   logic                         w_ack;
   logic                         w_wr;
   logic [WR_W-1:0]              w_written_nxt;

   assign w_start = i_start && (r_state == ST_IDLE);
   assign w_ack   = (r_state == ST_RUN) && i_pe_valid && (r_cool == '0) && (r_issued < r_rows);
   assign w_wr    = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && i_router_valid
                    && (r_written < r_total);

   // Look at the post-write count so DONE follows the last write by one cycle.
   assign w_written_nxt = r_written + {{(WR_W-1){1'b0}}, w_wr};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_rows    <= '0;
         r_issued  <= '0;
         r_total   <= '0;
         r_written <= '0;
         r_cool    <= '0;
         r_wr_addr <= '0;
         r_err     <= 1'b0;
      end else begin
         if (r_cool != '0) begin
            r_cool <= r_cool - c_cool_one;
         end
         if (i_router_valid && !w_wr) begin
            r_err <= 1'b1;
         end
         if (w_wr) begin
            r_wr_addr <= r_wr_addr + c_addr_one;
            r_written <= w_written_nxt;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_rows    <= i_row_count;
                  r_total   <= WR_W'(i_row_count) * c_group_w;
                  r_wr_addr <= i_base_addr;
                  r_issued  <= '0;
                  r_written <= '0;
                  r_cool    <= '0;
                  r_err     <= 1'b0;
                  r_state   <= (i_row_count != '0) ? ST_RUN : ST_DRAIN;
               end
            end
            ST_RUN: begin
               if (w_ack) begin
                  r_issued <= r_issued + c_row_one;
                  r_cool   <= c_cool_init;
                  if ((r_issued + c_row_one) == r_rows) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_written_nxt == r_total) begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_pe_ack     = w_ack;
   assign o_router_en  = w_ack;
   assign o_spad_wr_en = w_wr;
   assign o_spad_addr  = r_wr_addr;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = (r_state == ST_DONE);
   assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_output_writeback_ctrl.sv
// ============================================================================
// Module      : tb_output_writeback_ctrl
// Description : Self-checking bench with a row/word-level reference model and router stand-in.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_output_writeback_ctrl;

   // Router geometry for the default parameters: 16/8 -> 2 per word, 4/2 -> 2 words per row.
   localparam int G = 2;

   typedef struct {
      logic [7:0] base;
      logic [7:0] rows;
      int         mode;       // 0: valid always high, 1: random gaps, 2: late start + gaps
      bit         extra;      // inject a stray router valid after completion
      bit         midstart;   // pulse i_start while running
      int         exp_done;   // expected done cycle relative to start, -1 if timing is random
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_start;
   logic [7:0] i_base_addr;
   logic [7:0] i_row_count;
   logic       i_pe_valid;
   logic       o_pe_ack;
   logic       o_router_en;
   logic       i_router_valid;
   logic       o_spad_wr_en;
   logic [7:0] o_spad_addr;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   int n_tests = 0;
   int n_fail  = 0;

   output_writeback_ctrl dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_base_addr    (i_base_addr),
      .i_row_count    (i_row_count),
      .i_pe_valid     (i_pe_valid),
      .o_pe_ack       (o_pe_ack),
      .o_router_en    (o_router_en),
      .i_router_valid (i_router_valid),
      .o_spad_wr_en   (o_spad_wr_en),
      .o_spad_addr    (o_spad_addr),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_err          (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one job; the model expects rows acks, rows*G writes at base+k (mod 256), one done.
   task automatic run_scn(input vec_t v);
      int         cyc      = 0;
      int         acks     = 0;
      int         writes   = 0;
      int         dones    = 0;
      int         last_ack = -100;
      int         rv_rem   = 0;
      int         done_cyc = -1;
      int         en_diff  = 0;
      int         no_valid = 0;
      int         too_soon = 0;
      int         pv_low;
      int         total;
      int         budget;
      bit         acked;
      logic [7:0] exp_addr;

      total    = int'(v.rows) * G;
      budget   = 30 + int'(v.rows) * (G + 1) * 6;
      exp_addr = v.base;

      @(posedge i_clk); #1;
      i_start        = 1'b1;
      i_base_addr    = v.base;
      i_row_count    = v.rows;
      i_router_valid = 1'b0;
      pv_low         = (v.mode == 2) ? 4 : 0;
      i_pe_valid     = (v.mode != 2);

      while (cyc < budget) begin
         @(negedge i_clk);
         acked = o_pe_ack;
         if (cyc == 1) chk("err_clear_on_start", o_err, 0);
         if (o_router_en !== o_pe_ack) en_diff++;
         if (acked) begin
            if (!i_pe_valid) no_valid++;
            if (cyc - last_ack < G + 1) too_soon++;
            last_ack = cyc;
            acks++;
            rv_rem = G;
         end
         if (o_spad_wr_en) begin
            writes++;
            chk("wr_addr", o_spad_addr, exp_addr);
            exp_addr = exp_addr + 8'd1;
         end
         if (o_done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;

         @(posedge i_clk); #1;
         cyc++;
         i_start = 1'b0;
         if (v.midstart && cyc == 3) begin
            i_start     = 1'b1;
            i_base_addr = 8'hAA;
            i_row_count = 8'd9;
         end
         i_router_valid = (rv_rem > 0);
         if (rv_rem > 0) rv_rem--;
         if (v.extra && done_cyc >= 0 && cyc == done_cyc + 1) i_router_valid = 1'b1;
         if (acked) begin
            if (v.mode == 0)      pv_low = 0;
            else if (v.mode == 1) pv_low = int'($urandom_range(0, 3));
            else                  pv_low = int'($urandom_range(1, 3));
         end
         if (pv_low > 0) begin
            i_pe_valid = 1'b0;
            pv_low--;
         end else begin
            i_pe_valid = 1'b1;
         end
      end

      chk("done_seen", (done_cyc >= 0), 1);
      chk("ack_count", acks, v.rows);
      chk("write_count", writes, total);
      chk("done_pulses", dones, 1);
      chk("router_en_eq_ack", en_diff, 0);
      chk("ack_without_valid", no_valid, 0);
      chk("ack_spacing", too_soon, 0);
      if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
      chk("err_final", o_err, v.extra);
      chk("busy_final", o_busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      vec_t rv;
      int   w;

      tbl[0] = '{base: 8'h10, rows: 8'd3, mode: 0, extra: 1'b0, midstart: 1'b0, exp_done: 10};
      tbl[1] = '{base: 8'hFE, rows: 8'd2, mode: 0, extra: 1'b0, midstart: 1'b0, exp_done: 7};
      tbl[2] = '{base: 8'h00, rows: 8'd0, mode: 0, extra: 1'b0, midstart: 1'b0, exp_done: 2};
      tbl[3] = '{base: 8'h20, rows: 8'd3, mode: 2, extra: 1'b0, midstart: 1'b0, exp_done: -1};
      tbl[4] = '{base: 8'h30, rows: 8'd2, mode: 0, extra: 1'b1, midstart: 1'b1, exp_done: 7};
      tbl[5] = '{base: 8'h50, rows: 8'd1, mode: 0, extra: 1'b0, midstart: 1'b0, exp_done: 4};

      i_rst          = 1'b1;
      i_start        = 1'b0;
      i_base_addr    = 8'h00;
      i_row_count    = 8'h00;
      i_pe_valid     = 1'b0;
      i_router_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_pe_ack", o_pe_ack, 0);
      chk("rst_router_en", o_router_en, 0);
      chk("rst_wr_en", o_spad_wr_en, 0);
      chk("rst_addr", o_spad_addr, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);

      for (int i = 0; i < 6; i++) run_scn(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         rv.base     = 8'($urandom);
         rv.rows     = 8'($urandom_range(0, 5));
         rv.mode     = 1;
         rv.extra    = 1'($urandom_range(0, 1));
         rv.midstart = 1'b0;
         rv.exp_done = -1;
         run_scn(rv);
      end

      // Reset in the middle of the second row: acks at 1 and 4, router words at 2,3,5,6.
      @(posedge i_clk); #1;
      i_start        = 1'b1;
      i_base_addr    = 8'h40;
      i_row_count    = 8'd3;
      i_pe_valid     = 1'b1;
      i_router_valid = 1'b0;
      w = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         if (o_spad_wr_en) w++;
         if (c == 4) chk("rst_mid_ack_row2", o_pe_ack, 1);
         @(posedge i_clk); #1;
         i_start        = 1'b0;
         i_router_valid = (c + 1 == 2) || (c + 1 == 3) || (c + 1 == 5);
         i_rst          = (c + 1 == 5);
      end
      @(negedge i_clk);
      chk("rst_mid_writes", w, 3);
      chk("rst_mid_pe_ack", o_pe_ack, 0);
      chk("rst_mid_router_en", o_router_en, 0);
      chk("rst_mid_wr_en", o_spad_wr_en, 0);
      chk("rst_mid_addr", o_spad_addr, 0);
      chk("rst_mid_busy", o_busy, 0);
      chk("rst_mid_done", o_done, 0);
      chk("rst_mid_err", o_err, 0);

      rv = '{base: 8'h80, rows: 8'd2, mode: 0, extra: 1'b0, midstart: 1'b0, exp_done: 7};
      run_scn(rv);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
